// File: rtl/mips_register_file_pkg.sv
// Shared datapath constants for the MIPS register file, ALU and control blocks.
package mips_register_file_pkg;

    localparam int               DATA_W    = 32;
    localparam int               ADDR_W    = 5;
    localparam int               NUM_REGS  = 32;
    localparam logic [4:0]       REG_ZERO  = 5'd0;
    localparam logic [31:0]      RESET_VAL = 32'h0000_0000;

endpackage

// File: rtl/mips_register_file_reg32_en.sv
// One general-purpose register: DFFs with synchronous clear and a load enable.
module reg32_en
    import mips_register_file_pkg::*;
#(
    parameter int             W       = DATA_W,
    parameter logic [W-1:0]   RST_VAL = W'(RESET_VAL)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one synchronous
// write port, $0 hard-wired to zero, no write-to-read bypass.
module mips_register_file #(
    parameter int DATA_W = mips_register_file_pkg::DATA_W,
    parameter int ADDR_W = mips_register_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2
);

    import mips_register_file_pkg::*;

    localparam int NREGS = (ADDR_W == mips_register_file_pkg::ADDR_W) ? NUM_REGS : (1 << ADDR_W);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] reg_q [1:NREGS-1];
    logic [NREGS-1:1]  load_en;
    logic              write_ok;

    // Reset blocks the load so a colliding write is lost; index 0 has no storage.
    assign write_ok = reg_write & ~reset & (write_reg != ZERO_IDX);

    always_comb begin
        load_en = '0;
        for (int i = 1; i < NREGS; i++) begin
            load_en[i] = write_ok & (write_reg == ADDR_W'(i));
        end
    end

    for (genvar i = 1; i < NREGS; i++) begin : g_reg
        reg32_en #(
            .W       (DATA_W),
            .RST_VAL (DATA_W'(RESET_VAL))
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .load  (load_en[i]),
            .d     (write_data),
            .q     (reg_q[i])
        );
    end

    // Binary mux tree per port: level ADDR_W holds the leaves, level 0 the root.
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [ADDR_W-1:0] sel;

        if (p == 0) begin : g_sel1
            assign sel = read_reg_1;
        end else begin : g_sel2
            assign sel = read_reg_2;
        end

        for (genvar l = 0; l <= ADDR_W; l++) begin : g_lvl
            logic [DATA_W-1:0] node [2**l];

            for (genvar j = 0; j < 2**l; j++) begin : g_node
                if (l == ADDR_W) begin : g_leaf
                    if (j == 0) begin : g_zero
                        assign node[j] = '0;
                    end else begin : g_reg_leaf
                        assign node[j] = reg_q[j];
                    end
                end else begin : g_mux
                    assign node[j] = sel[ADDR_W-1-l] ? g_lvl[l+1].node[2*j+1]
                                                     : g_lvl[l+1].node[2*j];
                end
            end
        end

        if (p == 0) begin : g_out1
            assign read_data_1 = g_lvl[0].node[0];
        end else begin : g_out2
            assign read_data_2 = g_lvl[0].node[0];
        end
    end

endmodule

// File: doc/mips_register_file.md
# mips_register_file

General-purpose register file for the single-cycle MIPS datapath: 32 registers of 32 bits, two asynchronous read ports, one synchronous write port. It sits directly downstream of the ALU result path, including the 32-bit XOR unit. The write-back mux drives `write_data` from the ALU result, and `read_data_1`/`read_data_2` feed the ALU operand inputs on the next instruction. Register `$0` reads as zero at all times.

## Interface
Parameters:
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, register index width (2^ADDR_W registers)

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge
- `reset`  input  1  synchronous, active-high; clears every register on a rising edge of `clk`
- `reg_write`  input  1  write enable from the control unit
- `read_reg_1`  input  ADDR_W  index for read port 1 (rs)
- `read_reg_2`  input  ADDR_W  index for read port 2 (rt)
- `write_reg`  input  ADDR_W  write index (rd/rt, selected by RegDst upstream)
- `write_data`  input  DATA_W  write-back value (ALU/memory result)
- `read_data_1`  output  DATA_W  contents of `read_reg_1`
- `read_data_2`  output  DATA_W  contents of `read_reg_2`

## Operation
- Storage: 31 writable 32-bit registers, indices 1..31. Index 0 has no storage; its read value is the constant 0.
- Write: on a rising `clk` edge with `reset`=0, `reg_write`=1 and `write_reg`≠0, register[`write_reg`] ← `write_data`. All other registers hold.
- Write to index 0 is silently discarded. It is not an error, and no other register changes.
- `reg_write`=0: no register changes, whatever the values of `write_reg` and `write_data`.
- Reset: on a rising edge with `reset`=1, all registers go to 0x00000000. Reset dominates a simultaneous `reg_write`=1, and that write is lost.
- Reset asserted mid-program takes effect only at the next rising edge. Until that edge, reads return the pre-reset contents.
- Reads: purely combinational mux of current register state. Both ports are independent, may address the same register, and may address `$0` (returns 0).
- Decode path: 5-to-32 one-hot write decoder, gated by `reg_write`. Output 0 of the decoder is unused.

## Timing
- Read latency: combinational, same cycle as the address change. There is no clock on the read path.
- Write latency: the value written at edge N is visible on the read ports immediately after edge N.
- Read and write to the same index in one cycle: the read port returns the OLD value until the edge. There is no write-to-read bypass, because the single-cycle datapath does not need one.
- Reset value of every output: after a reset edge, `read_data_1` = `read_data_2` = 0x00000000 for every address.
- No handshake. One write per cycle maximum; the write port is always ready.

## Structure
- Shared constants file: `DATA_W`=32, `ADDR_W`=5, `NUM_REGS`=32, `REG_ZERO`=5'd0, `RESET_VAL`=32'h0. The ALU and control blocks share these constants.
- Sub-module `reg32_en`: one 32-bit register built from DFFs with synchronous reset and a load enable. It is instantiated 31 times.
- Read muxes: two 32:1 × 32-bit mux trees built from 2:1 mux primitives. Leaf 0 is tied to the constant zero.
- Write decoder: 5-to-32 decoder ANDed with `reg_write` and the inverted `reset`, driving each `reg32_en` load enable. Reset goes directly to each register's synchronous clear.

## Test plan
- Reset clear: load `$5`=0xDEADBEEF, then assert `reset` for 1 edge → reads of `$1`..`$31` all return 0x00000000.
- Basic write/read: write `$8`←0x12345678 and `$9`←0xA5A5A5A5 on consecutive edges. Then `read_reg_1`=8 and `read_reg_2`=9 → 0x12345678 / 0xA5A5A5A5 with no further clock.
- `$0` immunity: `reg_write`=1, `write_reg`=0, `write_data`=0xFFFFFFFF, one edge → `read_data_1`(0)=0, and `$1`..`$31` are unchanged.
- Enable gating: `reg_write`=0, `write_reg`=10, `write_data`=0x0000FFFF → `$10` keeps its prior value of 0x11111111.
- Same-cycle read/write: `$12`=0xCAFEF00D. Present write 0x00C0FFEE to `$12` while reading `$12` → before the edge 0xCAFEF00D, after the edge 0x00C0FFEE on both ports.
- Reset vs write collision: `reset`=1 and `reg_write`=1, `write_reg`=3, `write_data`=0x77777777, same edge → `$3`=0x00000000.
